// File: rtl/ercy_formatter_pkg.sv
// Shared definitions for the error-record formatter: state encoding, record and
// sector geometry, ASCII constants and the post-record dispatch rule.
package ercy_formatter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_SEND,
    ST_PAD,
    ST_DONE
  } state_e;

  localparam int RECLEN  = 16;
  localparam int SECTLEN = 512;

  localparam logic [3:0] LAST_IDX  = 4'(RECLEN - 1);
  localparam logic [8:0] LAST_SECT = 9'(SECTLEN - 1);

  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_ZERO  = 8'h30;
  localparam logic [7:0] ASC_A_M10 = 8'h37;

  // A waiting record always wins; otherwise a finished compare pads out the
  // current sector, or closes the file at once if the sector is already full.
  function automatic state_e next_idle(input logic empty, input logic done,
                                       input logic [8:0] sect_cnt);
    state_e nxt;
    nxt = ST_IDLE;
    if (!empty) begin
      nxt = ST_FETCH;
    end else if (done) begin
      nxt = (sect_cnt != 9'd0) ? ST_PAD : ST_DONE;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/ercy_formatter_hex2asc.sv
// Converts one 4-bit nibble to its uppercase ASCII hex digit.
module ercy_formatter_hex2asc
  import ercy_formatter_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] asc
);

  assign asc = (nib < 4'd10) ? (ASC_ZERO + {4'h0, nib}) : (ASC_A_M10 + {4'h0, nib});

endmodule

// File: rtl/ercy_formatter.sv
// Drains miscompare records from the error FIFOs and streams them as 16-byte
// ASCII lines into the SD write buffer, padding the final sector with spaces.
module ercy_formatter
  import ercy_formatter_pkg::*;
(
  input  logic        clk,
  input  logic        ureset,
  input  logic        outempty,
  input  logic        cmpdone,
  input  logic [31:0] vecin,
  input  logic        wsin,
  input  logic        gsin,
  input  logic [7:0]  sgnlnum,
  output logic        errrd,
  output logic [7:0]  bdata,
  output logic        bvalid,
  input  logic        bready,
  output logic        sectdone,
  output logic        ercydone,
  output logic [15:0] reccnt
);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [8:0]  sect_q, sect_d;
  logic [15:0] reccnt_q, reccnt_d;
  logic [31:0] vec_q, vec_d;
  logic [7:0]  sig_q, sig_d;
  logic        ws_q, ws_d;
  logic        gs_q, gs_d;

  logic [3:0]  nib;
  logic [7:0]  hex_asc;
  logic [7:0]  rec_byte;

  ercy_formatter_hex2asc u_hex2asc (
    .nib (nib),
    .asc (hex_asc)
  );

  // Single shared converter: select the nibble the current byte index needs.
  always_comb begin
    nib = 4'h0;
    if (idx_q < 4'd8) begin
      nib = vec_q[{~idx_q[2:0], 2'b00} +: 4];
    end else if (idx_q == 4'd9) begin
      nib = sig_q[7:4];
    end else if (idx_q == 4'd10) begin
      nib = sig_q[3:0];
    end
  end

  always_comb begin
    rec_byte = ASC_SPACE;
    case (idx_q)
      4'd8, 4'd11: rec_byte = ASC_SPACE;
      4'd12:       rec_byte = ASC_ZERO | {7'h00, ws_q};
      4'd13:       rec_byte = ASC_ZERO | {7'h00, gs_q};
      4'd14:       rec_byte = ASC_CR;
      4'd15:       rec_byte = ASC_LF;
      default:     rec_byte = hex_asc;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sect_d   = sect_q;
    reccnt_d = reccnt_q;
    vec_d    = vec_q;
    sig_d    = sig_q;
    ws_d     = ws_q;
    gs_d     = gs_q;
    errrd    = 1'b0;
    bvalid   = 1'b0;
    bdata    = 8'h00;
    sectdone = 1'b0;
    ercydone = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = next_idle(outempty, cmpdone, sect_q);
      end
      ST_FETCH: begin
        errrd   = 1'b1;
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        vec_d   = vecin;
        sig_d   = sgnlnum;
        ws_d    = wsin;
        gs_d    = gsin;
        idx_d   = 4'd0;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        bvalid = 1'b1;
        bdata  = rec_byte;
        if (bready) begin
          idx_d    = idx_q + 4'd1;
          sect_d   = sect_q + 9'd1;
          sectdone = (sect_q == LAST_SECT);
          if (idx_q == LAST_IDX) begin
            reccnt_d = (reccnt_q == 16'hFFFF) ? reccnt_q : reccnt_q + 16'd1;
            state_d  = next_idle(outempty, cmpdone, sect_d);
          end
        end
      end
      ST_PAD: begin
        bvalid = 1'b1;
        bdata  = ASC_SPACE;
        if (bready) begin
          sect_d = sect_q + 9'd1;
          if (sect_q == LAST_SECT) begin
            sectdone = 1'b1;
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        ercydone = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (ureset) begin
      state_q  <= ST_IDLE;
      idx_q    <= 4'd0;
      sect_q   <= 9'd0;
      reccnt_q <= 16'd0;
      vec_q    <= 32'd0;
      sig_q    <= 8'd0;
      ws_q     <= 1'b0;
      gs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sect_q   <= sect_d;
      reccnt_q <= reccnt_d;
      vec_q    <= vec_d;
      sig_q    <= sig_d;
      ws_q     <= ws_d;
      gs_q     <= gs_d;
    end
  end

  assign reccnt = reccnt_q;

endmodule

// File: tb/tb_ercy_formatter.sv
// Self-checking bench for ercy_formatter: a FIFO model feeds records and a
// byte-stream model of the expected file is checked against the DUT each cycle.
module tb_ercy_formatter;

  typedef struct packed {
    logic [31:0] vec;
    logic [7:0]  sig;
    logic        ws;
    logic        gs;
  } rec_t;

  logic        clk = 1'b0;
  logic        ureset, outempty, cmpdone, wsin, gsin, bready;
  logic [31:0] vecin;
  logic [7:0]  sgnlnum;
  logic        errrd, bvalid, sectdone, ercydone;
  logic [7:0]  bdata;
  logic [15:0] reccnt;

  rec_t        fifo[$];
  logic [8:0]  exp_q[$];
  logic [7:0]  got[0:2047];
  int          total = 0;
  int          bad = 0;
  int          byte_cnt = 0;
  int          exp_reccnt = 0;
  int          sect_pulses = 0;
  int          errrd_pulses = 0;
  int          bvalid_cycles = 0;
  int          lat = 0;
  int          bready_mode = 0;
  logic        prev_errrd = 1'b0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  always #5 clk = ~clk;

  ercy_formatter dut (
    .clk      (clk),
    .ureset   (ureset),
    .outempty (outempty),
    .cmpdone  (cmpdone),
    .vecin    (vecin),
    .wsin     (wsin),
    .gsin     (gsin),
    .sgnlnum  (sgnlnum),
    .errrd    (errrd),
    .bdata    (bdata),
    .bvalid   (bvalid),
    .bready   (bready),
    .sectdone (sectdone),
    .ercydone (ercydone),
    .reccnt   (reccnt)
  );

  function automatic logic [7:0] hexChar(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected text of one record, the LF byte tagged as the record's last byte.
  task automatic appendRecord(input rec_t r);
    for (int i = 7; i >= 0; i--) exp_q.push_back({1'b0, hexChar(r.vec[i*4 +: 4])});
    exp_q.push_back({1'b0, 8'h20});
    exp_q.push_back({1'b0, hexChar(r.sig[7:4])});
    exp_q.push_back({1'b0, hexChar(r.sig[3:0])});
    exp_q.push_back({1'b0, 8'h20});
    exp_q.push_back({1'b0, 8'h30 + {7'h00, r.ws}});
    exp_q.push_back({1'b0, 8'h30 + {7'h00, r.gs}});
    exp_q.push_back({1'b0, 8'h0D});
    exp_q.push_back({1'b1, 8'h0A});
  endtask

  task automatic modelCompare();
    logic       accept;
    logic       pad_ok;
    logic [8:0] e;
    if (ureset) begin
      exp_q.delete();
      byte_cnt   = 0;
      exp_reccnt = 0;
      lat        = 0;
      prev_stall = 1'b0;
      prev_errrd = 1'b0;
      return;
    end
    checkOutput("reccnt", reccnt, exp_reccnt);
    if (lat > 0) begin
      lat--;
      if (lat == 0) checkOutput("first_byte_latency", bvalid, 1);
    end
    if (errrd) begin
      checkOutput("errrd_while_empty", outempty, 0);
      checkOutput("errrd_multi_cycle", prev_errrd, 0);
      errrd_pulses++;
      if (fifo.size() > 0) appendRecord(fifo[0]);
      lat = 2;
    end
    if (prev_stall) begin
      checkOutput("stall_bvalid", bvalid, 1);
      checkOutput("stall_bdata", bdata, prev_data);
    end
    pad_ok = (exp_q.size() == 0) && cmpdone && ((byte_cnt % 512) != 0);
    accept = bvalid && bready;
    checkOutput("sectdone", sectdone, accept && ((byte_cnt % 512) == 511));
    if (bvalid) begin
      bvalid_cycles++;
      if (exp_q.size() > 0) checkOutput("bdata", bdata, exp_q[0][7:0]);
      else if (pad_ok) checkOutput("pad_byte", bdata, 8'h20);
      else checkOutput("unexpected_bvalid", bvalid, 0);
    end
    if (accept) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e[8]) exp_reccnt++;
      end
      if (byte_cnt < 2048) got[byte_cnt] = bdata;
      byte_cnt++;
      if (sectdone) sect_pulses++;
    end
    if (ercydone) begin
      checkOutput("done_quiet", {28'h0, bvalid, errrd, (exp_q.size() != 0 || fifo.size() != 0),
                  ((byte_cnt % 512) != 0)}, 0);
    end
    prev_stall = bvalid && !bready;
    prev_data  = bdata;
    prev_errrd = errrd;
  endtask

  // One clock: compare on the falling edge, then update the FIFO model and
  // inputs just after the rising edge.
  task automatic applyStimulus(input int n);
    logic pop_now;
    rec_t r;
    repeat (n) begin
      @(negedge clk);
      modelCompare();
      pop_now = errrd;
      @(posedge clk);
      #1;
      if (pop_now && fifo.size() > 0) begin
        r       = fifo.pop_front();
        vecin   = r.vec;
        sgnlnum = r.sig;
        wsin    = r.ws;
        gsin    = r.gs;
      end
      outempty = (fifo.size() == 0);
      case (bready_mode)
        0:       bready = 1'b1;
        1:       bready = ~bready;
        default: bready = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  task automatic pushRecord(input rec_t r);
    fifo.push_back(r);
    outempty = 1'b0;
  endtask

  task automatic pushRandom(input int n);
    rec_t r;
    for (int i = 0; i < n; i++) begin
      r.vec = $urandom;
      r.sig = 8'($urandom_range(0, 255));
      r.ws  = 1'($urandom_range(0, 1));
      r.gs  = 1'($urandom_range(0, 1));
      pushRecord(r);
    end
  endtask

  task automatic waitReccnt(input int target, input int budget);
    int k = 0;
    while (int'(reccnt) != target && k < budget) begin
      applyStimulus(1);
      k++;
    end
    checkOutput("wait_reccnt", reccnt, target);
  endtask

  task automatic waitBytes(input int target, input int budget);
    int k = 0;
    while (byte_cnt < target && k < budget) begin
      applyStimulus(1);
      k++;
    end
    checkOutput("wait_bytes", byte_cnt, target);
  endtask

  task automatic waitDone(input int budget);
    int k = 0;
    while (!ercydone && k < budget) begin
      applyStimulus(1);
      k++;
    end
    checkOutput("wait_ercydone", ercydone, 1);
  endtask

  task automatic checkKnownRecord(input int base);
    string lit;
    lit = "000000A5 13 10";
    for (int i = 0; i < 14; i++) checkOutput($sformatf("lit_byte%0d", base + i), got[base + i], lit[i]);
    checkOutput("lit_cr", got[base + 14], 8'h0D);
    checkOutput("lit_lf", got[base + 15], 8'h0A);
  endtask

  initial begin
    rec_t known;
    int   bv0;
    int   sp0;
    known   = '{vec: 32'h0000_00A5, sig: 8'h13, ws: 1'b1, gs: 1'b0};
    ureset  = 1'b1;
    outempty = 1'b1;
    cmpdone = 1'b0;
    vecin   = 32'h0;
    sgnlnum = 8'h0;
    wsin    = 1'b0;
    gsin    = 1'b0;
    bready  = 1'b1;
    applyStimulus(3);
    checkOutput("rst_errrd", errrd, 0);
    checkOutput("rst_bvalid", bvalid, 0);
    checkOutput("rst_bdata", bdata, 8'h00);
    checkOutput("rst_sectdone", sectdone, 0);
    checkOutput("rst_ercydone", ercydone, 0);
    checkOutput("rst_reccnt", reccnt, 0);
    ureset = 1'b0;

    // Single known record with a free-running buffer.
    bready_mode = 0;
    pushRecord(known);
    waitReccnt(1, 60);
    checkOutput("errrd_pulses", errrd_pulses, 1);
    checkKnownRecord(0);

    // Same record with the buffer stalling every other cycle.
    bready_mode = 1;
    bv0 = bvalid_cycles;
    pushRecord(known);
    waitReccnt(2, 100);
    checkKnownRecord(16);
    checkOutput("toggle_send_cycles", (bvalid_cycles - bv0 >= 31) && (bvalid_cycles - bv0 <= 32), 1);

    // Random records to 31, then two more arriving together with cmpdone.
    bready_mode = 2;
    pushRandom(29);
    waitReccnt(31, 3000);
    pushRandom(2);
    cmpdone = 1'b1;
    waitDone(2500);
    checkOutput("final_reccnt", reccnt, 33);
    checkOutput("final_bytes", byte_cnt, 1024);
    checkOutput("final_sectdones", sect_pulses, 2);
    checkOutput("rec33_lf", got[527], 8'h0A);
    checkOutput("pad_first", got[528], 8'h20);
    checkOutput("pad_last", got[1023], 8'h20);

    // Reset while byte 7 of a record is on the bus.
    cmpdone = 1'b0;
    ureset  = 1'b1;
    applyStimulus(1);
    ureset  = 1'b0;
    bready_mode = 0;
    pushRecord(known);
    waitBytes(7, 40);
    ureset = 1'b1;
    applyStimulus(1);
    ureset = 1'b0;
    checkOutput("midrst_bvalid", bvalid, 0);
    checkOutput("midrst_reccnt", reccnt, 0);
    checkOutput("midrst_errrd", errrd, 0);
    sp0 = sect_pulses;
    applyStimulus(3);
    checkOutput("midrst_quiet", bvalid, 0);
    pushRecord(known);
    waitReccnt(1, 60);
    checkKnownRecord(0);
    cmpdone = 1'b1;
    waitDone(1200);
    checkOutput("midrst_bytes", byte_cnt, 512);
    checkOutput("midrst_sectdone", sect_pulses - sp0, 1);

    // cmpdone straight out of reset with nothing to write.
    cmpdone = 1'b0;
    ureset  = 1'b1;
    applyStimulus(2);
    ureset  = 1'b0;
    cmpdone = 1'b1;
    sp0 = sect_pulses;
    applyStimulus(2);
    checkOutput("empty_ercydone", ercydone, 1);
    checkOutput("empty_bytes", byte_cnt, 0);
    checkOutput("empty_sectdone", sect_pulses - sp0, 0);
    applyStimulus(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
